// File: rtl/fifo_rd_stream.sv
// Read-side streaming adapter: pulls words from a FIFO read port with one-cycle read latency
// and presents them as a valid/ready stream through a 2-entry skid buffer.
module fifo_rd_stream #(
  parameter int unsigned DATA_WIDTH = 6,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rst,
  input  logic                  EMPTY,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  // Buffer occupancy encoding.
  localparam logic [1:0] EMPTY_B = 2'd0;
  localparam logic [1:0] ONE     = 2'd1;
  localparam logic [1:0] TWO     = 2'd2;

  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;  // oldest word, drives m_data
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
  logic [CNT_WIDTH-1:0]  cnt_q;

  logic       pop;
  logic       push;
  logic [2:0] outstanding;

  assign m_valid  = (occ_q != EMPTY_B);
  assign m_data   = buf0_q;
  assign word_cnt = cnt_q;

  assign pop  = m_valid & m_ready;
  assign push = inflight_q;

  // Words that will still occupy the buffer after this cycle's pop, counting the one in flight.
  assign outstanding = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

  // Only request when the returning word is guaranteed a free slot.
  assign rd_en = ~EMPTY & (outstanding < 3'd2) & ~rst;

  // Next buffer contents and occupancy from the push/pop combination.
  always_comb begin
    occ_d  = occ_q;
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    case ({push, pop})
      2'b10: begin
        occ_d = occ_q + 2'd1;
        if (occ_q == EMPTY_B) begin
          buf0_d = data_out;
        end else begin
          buf1_d = data_out;
        end
      end
      2'b01: begin
        occ_d  = occ_q - 2'd1;
        buf0_d = buf1_q;
      end
      2'b11: begin
        if (occ_q == TWO) begin
          buf0_d = buf1_q;
          buf1_d = data_out;
        end else if (occ_q == ONE) begin
          buf0_d = data_out;
        end
      end
      default: begin
      end
    endcase
  end

  // State registers; reset discards buffered and in-flight words.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      occ_q      <= EMPTY_B;
      inflight_q <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      cnt_q      <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= rd_en;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      if (pop) begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: queue-based reference model checked every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_fifo_rd_stream;

  localparam int DW = 6;

  logic          rd_clk;
  logic          rst;
  logic          EMPTY;
  logic [DW-1:0] data_out;
  logic          m_ready;
  logic          rd_en, rd_en4;
  logic          m_valid, m_valid4;
  logic [DW-1:0] m_data, m_data4;
  logic [15:0]   word_cnt;
  logic [3:0]    word_cnt4;

  fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
    .rd_clk   (rd_clk),
    .rst      (rst),
    .EMPTY    (EMPTY),
    .data_out (data_out),
    .rd_en    (rd_en),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_ready  (m_ready),
    .word_cnt (word_cnt)
  );

  // Narrow-counter copy sharing the same stimulus; only its counter is of interest.
  fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut4 (
    .rd_clk   (rd_clk),
    .rst      (rst),
    .EMPTY    (EMPTY),
    .data_out (data_out),
    .rd_en    (rd_en4),
    .m_valid  (m_valid4),
    .m_data   (m_data4),
    .m_ready  (m_ready),
    .word_cnt (word_cnt4)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Source FIFO contents (stimulus) and the model's own copy of it.
  logic [DW-1:0] src[$];
  logic [DW-1:0] msrc[$];

  // Reference model: buffered words as a queue, one optional word on its way back.
  logic [DW-1:0] mq[$];
  int            m_infl = 0;
  logic [DW-1:0] m_word = '0;
  int            cnt = 0;
  logic          e_valid = 1'b0, e_pop = 1'b0, e_rd = 1'b0;

  // Monitors.
  int            cyc = 0;
  logic          fetch_s = 1'b0;
  logic [DW-1:0] got[$];
  int            hs = 0;
  int            rd_pulses = 0;
  bit            track = 1'b0;
  int            first_rd = -1;
  int            first_v = -1;

  // Compare process: outputs against the model, mid-cycle with inputs settled.
  always @(negedge rd_clk) begin
    e_valid = (mq.size() > 0);
    e_pop   = e_valid && m_ready;
    e_rd    = !EMPTY && !rst && ((mq.size() + m_infl - (e_pop ? 1 : 0)) < 2);
    chk("rd_en", 32'(rd_en), 32'(e_rd));
    chk("m_valid", 32'(m_valid), 32'(e_valid));
    if (e_valid) chk("m_data", 32'(m_data), 32'(mq[0]));
    chk("word_cnt", 32'(word_cnt), cnt & 32'hffff);
    chk("word_cnt4", 32'(word_cnt4), cnt & 32'hf);

    fetch_s = rd_en;
    if (m_valid && m_ready) begin
      got.push_back(m_data);
      hs++;
    end
    if (rd_en) rd_pulses++;
    if (track) begin
      if (rd_en && first_rd < 0) first_rd = cyc;
      if (m_valid && first_v < 0) first_v = cyc;
    end
  end

  // Model state advance at the clock edge.
  always @(posedge rd_clk) begin
    cyc++;
    if (rst) begin
      mq.delete();
      m_infl = 0;
      cnt    = 0;
    end else begin
      if (e_pop) begin
        void'(mq.pop_front());
        cnt++;
      end
      if (m_infl != 0) mq.push_back(m_word);
      m_infl = e_rd ? 1 : 0;
      if (e_rd && msrc.size() > 0) m_word = msrc.pop_front();
    end
  end

  // Advance one cycle; present fetched data (or junk) one cycle after a read.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge rd_clk);
      #1;
      if (fetch_s && src.size() > 0) data_out = src.pop_front();
      else data_out = DW'($urandom);
      EMPTY = (src.size() == 0);
    end
  endtask

  task automatic load(input logic [DW-1:0] w);
    src.push_back(w);
    msrc.push_back(w);
    EMPTY = 1'b0;
  endtask

  logic [DW-1:0] pat[8];

  initial begin
    pat[0] = 6'b101010; pat[1] = 6'b010101; pat[2] = 6'b000001; pat[3] = 6'b000010;
    pat[4] = 6'b000100; pat[5] = 6'b001000; pat[6] = 6'b010000; pat[7] = 6'b100000;

    rst = 1'b1; m_ready = 1'b1; EMPTY = 1'b1; data_out = '0;
    tick(3);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);

    // Idle with an empty FIFO.
    rst = 1'b0;
    tick(10);
    chk("idle_rd_en", 32'(rd_en), 32'd0);
    chk("idle_m_valid", 32'(m_valid), 32'd0);
    chk("idle_word_cnt", 32'(word_cnt), 32'd0);

    // Streaming 8 words with m_ready held high.
    got.delete(); track = 1'b1; first_rd = -1; first_v = -1;
    for (int i = 0; i < 8; i++) load(pat[i]);
    tick(14);
    track = 1'b0;
    chk("latency", 32'(first_v - first_rd), 32'd2);
    chk("stream_count", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("stream_order", 32'(got[i]), 32'(pat[i]));
    chk("stream_word_cnt", 32'(word_cnt), 32'd8);
    chk("stream_rd_en_drop", 32'(rd_en), 32'd0);

    // Backpressure: only two reads may be outstanding.
    got.delete(); m_ready = 1'b0; rd_pulses = 0;
    for (int i = 0; i < 8; i++) load(pat[i]);
    tick(6);
    chk("stall_rd_pulses", 32'(rd_pulses), 32'd2);
    chk("stall_m_valid", 32'(m_valid), 32'd1);
    chk("stall_m_data", 32'(m_data), 32'(6'b101010));
    m_ready = 1'b1;
    tick(12);
    chk("stall_count", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("stall_order", 32'(got[i]), 32'(pat[i]));
    chk("stall_word_cnt", 32'(word_cnt), 32'd16);

    // Toggling m_ready with continuous supply.
    got.delete(); hs = 0;
    for (int i = 0; i < 12; i++) load(pat[i % 8]);
    for (int i = 0; i < 16; i++) begin
      m_ready = (i % 2 == 0);
      tick(1);
    end
    chk("toggle_cnt_vs_hs", 32'(word_cnt), 32'(16 + hs));
    m_ready = 1'b1;
    tick(10);
    chk("toggle_count", 32'(got.size()), 32'd12);
    for (int i = 0; i < 12 && i < got.size(); i++) chk("toggle_order", 32'(got[i]), 32'(pat[i % 8]));
    chk("toggle_word_cnt", 32'(word_cnt), 32'd28);

    // Reset while the buffer holds a word and another is in flight.
    got.delete(); m_ready = 1'b0;
    for (int i = 0; i < 8; i++) load(pat[i]);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midrst_m_valid", 32'(m_valid), 32'd0);
    chk("midrst_word_cnt", 32'(word_cnt), 32'd0);
    m_ready = 1'b1;
    tick(12);
    chk("midrst_count", 32'(got.size()), 32'd6);
    if (got.size() > 0) chk("midrst_first", 32'(got[0]), 32'(pat[2]));
    chk("midrst_word_cnt_after", 32'(word_cnt), 32'd6);

    // Counter wrap on the 4-bit instance.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int i = 0; i < 17; i++) load(DW'(i * 5 + 3));
    tick(24);
    chk("wrap_word_cnt4", 32'(word_cnt4), 32'd1);
    chk("wrap_word_cnt", 32'(word_cnt), 32'd17);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
